// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - MEM/WB pipeline register with sub-word load alignment and extension
module mem_wb #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] mem_wd,
   input  logic              mem_wreg,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [2:0]        mem_ldop,
   input  logic [1:0]        mem_addr_lo,
   input  logic              stall_mem,
   input  logic              stall_wb,
   input  logic              flush,
   output logic [ADDR_W-1:0] wb_wd,
   output logic              wb_wreg,
   output logic [DATA_W-1:0] wb_wdata,
   output logic              wb_misalign
);

   localparam logic [2:0] LD_LB  = 3'b001;
   localparam logic [2:0] LD_LBU = 3'b010;
   localparam logic [2:0] LD_LH  = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;
   localparam logic [2:0] LD_LW  = 3'b101;

   logic [1:0]        byte_lane;
   logic              half_lane;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] load_val;
   logic              misalign;

   // Big-endian puts offset 0 in the most significant lane.
   assign byte_lane = BIG_ENDIAN ? ~mem_addr_lo : mem_addr_lo;
   assign half_lane = BIG_ENDIAN ? ~mem_addr_lo[1] : mem_addr_lo[1];
   assign byte_sel  = mem_rdata[{byte_lane, 3'b000} +: 8];
   assign half_sel  = mem_rdata[{half_lane, 4'b0000} +: 16];

   always_comb begin
      load_val = mem_wdata;
      misalign = 1'b0;
      case (mem_ldop)
         LD_LB:  load_val = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LD_LBU: load_val = {{(DATA_W-8){1'b0}}, byte_sel};
         LD_LH: begin
            load_val = {{(DATA_W-16){half_sel[15]}}, half_sel};
            misalign = mem_addr_lo[0];
         end
         LD_LHU: begin
            load_val = {{(DATA_W-16){1'b0}}, half_sel};
            misalign = mem_addr_lo[0];
         end
         LD_LW: begin
            load_val = mem_rdata;
            misalign = |mem_addr_lo;
         end
         default: load_val = mem_wdata;
      endcase
   end

   // Flush beats a full stall; a MEM-only stall inserts a bubble into WB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_wd       <= '0;
         wb_wreg     <= 1'b0;
         wb_wdata    <= '0;
         wb_misalign <= 1'b0;
      end else if (flush || (stall_mem && !stall_wb)) begin
         wb_wd       <= '0;
         wb_wreg     <= 1'b0;
         wb_wdata    <= '0;
         wb_misalign <= 1'b0;
      end else if (!(stall_mem && stall_wb)) begin
         wb_wd       <= mem_wd;
         wb_wreg     <= mem_wreg & ~misalign;
         wb_wdata    <= misalign ? '0 : load_val;
         wb_misalign <= misalign;
      end
   end

endmodule
